// File: rtl/song_sequencer.sv
// song_sequencer: tempo-driven note ROM player with explicit per-note durations.
// Optional build macro SEQ_NOTE_GAP_EN silences the final GAP_CYCLES clocks of every note.
module song_sequencer #(
    parameter int CLK_HZ     = 1000000,
    parameter int TICK_HZ    = 4,
    parameter int SONG_LEN   = 64,
    parameter int GAP_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       auto_sw,
    input  logic       pause,
    output logic [2:0] pitch,
    output logic [6:0] tone,
    output logic [6:0] note_idx,
    output logic       note_start,
    output logic       playing
);
    localparam int TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int TW       = $clog2(TICK_DIV);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [TW-1:0] GAP_FROM  = TW'(TICK_DIV - GAP_CYCLES);
    localparam logic [6:0]    IDX_LAST  = 7'(SONG_LEN - 1);
`ifdef SEQ_NOTE_GAP_EN
    localparam bit GAP_EN = 1'b1;
`else
    localparam bit GAP_EN = 1'b0;
`endif

    localparam logic [2:0] RS = 3'b000;
    localparam logic [2:0] LO = 3'b100;
    localparam logic [2:0] MI = 3'b010;
    localparam logic [2:0] HI = 3'b001;
    localparam logic [6:0] D0 = 7'b0000000;
    localparam logic [6:0] D1 = 7'b0000001;
    localparam logic [6:0] D2 = 7'b0000010;
    localparam logic [6:0] D3 = 7'b0000100;
    localparam logic [6:0] D4 = 7'b0001000;
    localparam logic [6:0] D5 = 7'b0010000;
    localparam logic [6:0] D6 = 7'b0100000;
    localparam logic [6:0] D7 = 7'b1000000;

    typedef enum logic [1:0] {IDLE, PLAY, PAUSE} state_t;

    state_t        state_q, state_d;
    logic [6:0]    idx_q, idx_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [2:0]    dur_q, dur_d;
    logic [9:0]    snd_q, snd_d;
    logic          ld_q, ld_d;
    logic          tick, gap;
    logic [6:0]    nxt_idx;
    logic [12:0]   nxt;

    // Score: {pitch, tone, dur}; a 32-entry phrase, repeated when SONG_LEN exceeds it.
    function automatic logic [12:0] rom(input logic [4:0] a);
        case (a)
            5'd0:    rom = {LO, D6, 3'd0};
            5'd1:    rom = {LO, D7, 3'd0};
            5'd2:    rom = {MI, D1, 3'd2};
            5'd3:    rom = {MI, D3, 3'd1};
            5'd4:    rom = {MI, D2, 3'd0};
            5'd5:    rom = {MI, D1, 3'd1};
            5'd6:    rom = {RS, D0, 3'd1};
            5'd7:    rom = {MI, D5, 3'd3};
            5'd8:    rom = {MI, D5, 3'd0};
            5'd9:    rom = {HI, D1, 3'd2};
            5'd10:   rom = {MI, D6, 3'd0};
            5'd11:   rom = {MI, D5, 3'd1};
            5'd12:   rom = {MI, D3, 3'd0};
            5'd13:   rom = {MI, D2, 3'd0};
            5'd14:   rom = {MI, D1, 3'd7};
            5'd15:   rom = {RS, D0, 3'd0};
            5'd16:   rom = {MI, D3, 3'd0};
            5'd17:   rom = {MI, D3, 3'd0};
            5'd18:   rom = {MI, D4, 3'd1};
            5'd19:   rom = {MI, D5, 3'd1};
            5'd20:   rom = {MI, D5, 3'd0};
            5'd21:   rom = {MI, D4, 3'd0};
            5'd22:   rom = {MI, D3, 3'd1};
            5'd23:   rom = {MI, D2, 3'd1};
            5'd24:   rom = {MI, D1, 3'd0};
            5'd25:   rom = {MI, D1, 3'd0};
            5'd26:   rom = {MI, D2, 3'd1};
            5'd27:   rom = {MI, D3, 3'd1};
            5'd28:   rom = {MI, D3, 3'd2};
            5'd29:   rom = {MI, D2, 3'd0};
            5'd30:   rom = {MI, D2, 3'd3};
            default: rom = {RS, D0, 3'd1};
        endcase
    endfunction

    // Tempo tick, next entry lookup and end-of-note gap window.
    always_comb begin
        tick    = state_q == PLAY && tick_q == TICK_LAST;
        nxt_idx = (state_q == IDLE || idx_q == IDX_LAST) ? 7'd0 : idx_q + 7'd1;
        nxt     = rom(nxt_idx[4:0]);
        gap     = GAP_EN && dur_q == 3'd0 && tick_q >= GAP_FROM;
    end

    // Next state: auto_sw low wins, IDLE loads entry 0, PLAY advances counters, PAUSE freezes them.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        tick_d  = tick_q;
        dur_d   = dur_q;
        snd_d   = snd_q;
        ld_d    = 1'b0;
        if (!auto_sw) begin
            state_d = IDLE;
            idx_d   = 7'd0;
            tick_d  = '0;
            dur_d   = 3'd0;
        end else if (state_q == IDLE) begin
            state_d = PLAY;
            idx_d   = nxt_idx;
            tick_d  = '0;
            dur_d   = nxt[2:0];
            snd_d   = nxt[12:3];
            ld_d    = 1'b1;
        end else begin
            state_d = pause ? PAUSE : PLAY;
            if (state_q == PLAY) begin
                tick_d = tick ? '0 : tick_q + 1'b1;
                if (tick && dur_q == 3'd0) begin
                    idx_d = nxt_idx;
                    dur_d = nxt[2:0];
                    snd_d = nxt[12:3];
                    ld_d  = 1'b1;
                end else if (tick) begin
                    dur_d = dur_q - 3'd1;
                end
            end
        end
    end

    // Sequencer state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= 7'd0;
            tick_q  <= '0;
            dur_q   <= 3'd0;
            snd_q   <= 10'd0;
            ld_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tick_q  <= tick_d;
            dur_q   <= dur_d;
            snd_q   <= snd_d;
            ld_q    <= ld_d;
        end
    end

    // Registered outputs: silent unless playing, index held in PAUSE and zero in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pitch      <= 3'b000;
            tone       <= 7'd0;
            note_idx   <= 7'd0;
            note_start <= 1'b0;
            playing    <= 1'b0;
        end else begin
            pitch      <= (state_q == PLAY && !gap) ? snd_q[9:7] : 3'b000;
            tone       <= (state_q == PLAY && !gap) ? snd_q[6:0] : 7'd0;
            note_idx   <= state_q == IDLE ? 7'd0 : idx_q;
            note_start <= ld_q;
            playing    <= state_q != IDLE;
        end
    end
endmodule

// File: tb/tb_song_sequencer.sv
// tb_song_sequencer: scenario tasks plus a note-time reference model for song_sequencer.
module tb_song_sequencer;
    localparam int SL  = 64;
    localparam int TD  = 4;
    localparam int GAP = 1;
`ifdef SEQ_NOTE_GAP_EN
    localparam bit GAP_ON = 1'b1;
`else
    localparam bit GAP_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       auto_sw = 1'b0;
    logic       pause = 1'b0;
    logic [2:0] pitch;
    logic [6:0] tone;
    logic [6:0] note_idx;
    logic       note_start;
    logic       playing;

    song_sequencer #(.CLK_HZ(16), .TICK_HZ(4), .SONG_LEN(SL), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .rst_n(rst_n), .auto_sw(auto_sw), .pause(pause),
        .pitch(pitch), .tone(tone), .note_idx(note_idx),
        .note_start(note_start), .playing(playing)
    );

    always #5 clk = ~clk;

    // Score as musician-level data: range (4 low, 2 mid, 1 high, 0 rest), degree 1..7 (0 rest), length in ticks.
    int s_pit [32] = '{4,4,2,2,2,2,0,2,2,1,2,2,2,2,2,0, 2,2,2,2,2,2,2,2,2,2,2,2,2,2,2,0};
    int s_deg [32] = '{6,7,1,3,2,1,0,5,5,1,6,5,3,2,1,0, 3,3,4,5,5,4,3,2,1,1,2,3,3,2,2,0};
    int s_tk  [32] = '{1,1,3,2,1,2,2,4,1,3,1,2,1,1,8,1, 1,1,2,2,1,1,2,2,1,1,2,2,3,1,4,2};

    int n_chk = 0;
    int n_fail = 0;
    int cyc;

    bit m_on, m_paused, m_ld;
    int m_idx, m_rem;
    logic [2:0] e_pitch;
    logic [6:0] e_tone, e_idx;
    logic e_start, e_play;

    task automatic mreset();
        m_on = 0; m_paused = 0; m_ld = 0; m_idx = 0; m_rem = 0;
    endtask

    // Apply inputs for one edge; the model predicts the post-edge outputs from its pre-edge note state.
    task automatic adv(input logic a, input logic p);
        bit sil;
        auto_sw = a;
        pause = p;
        sil = !m_on || m_paused || (GAP_ON && m_rem <= GAP);
        e_pitch = sil ? 3'd0 : 3'(s_pit[m_idx % 32]);
        e_tone = (sil || s_deg[m_idx % 32] == 0) ? 7'd0 : 7'(1 << (s_deg[m_idx % 32] - 1));
        e_idx = m_on ? 7'(m_idx) : 7'd0;
        e_start = m_ld;
        e_play = m_on;
        @(posedge clk);
        m_ld = 0;
        if (!m_on) begin
            if (a) begin
                m_on = 1; m_paused = 0; m_idx = 0; m_rem = TD * s_tk[0]; m_ld = 1;
            end
        end else if (!a) begin
            m_on = 0;
        end else begin
            if (!m_paused) begin
                m_rem--;
                if (m_rem == 0) begin
                    m_idx = (m_idx + 1) % SL;
                    m_rem = TD * s_tk[m_idx % 32];
                    m_ld = 1;
                end
            end
            m_paused = p;
        end
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst_n = 0; auto_sw = 0; pause = 0;
        mreset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        cyc = -1;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        n_chk++;
        if ({pitch, tone, note_idx, note_start, playing} !== 19'd0) begin
            n_fail++;
            $display("FAIL reset_held got %b_%b_%0d_%b_%b want all zero", pitch, tone, note_idx, note_start, playing);
        end
        do_reset();
        for (int k = 0; k < 8; k++) begin
            adv(1'b0, 1'b0);
            n_chk++;
            if ({pitch, tone, note_idx, note_start, playing} !== 19'd0) begin
                n_fail++;
                $display("FAIL reset_idle cyc=%0d got %b_%b_%0d_%b_%b want all zero", cyc, pitch, tone, note_idx, note_start, playing);
            end
        end
    endtask

    task automatic test_start();
        do_reset();
        for (int k = 0; k <= 21; k++) begin
            adv(1'b1, 1'b0);
            n_chk++;
            if ({pitch, tone, note_idx, note_start, playing} !== {e_pitch, e_tone, e_idx, e_start, e_play}) begin
                n_fail++;
                $display("FAIL start_model cyc=%0d got %b_%b_%0d_%b_%b want %b_%b_%0d_%b_%b", cyc,
                         pitch, tone, note_idx, note_start, playing, e_pitch, e_tone, e_idx, e_start, e_play);
            end
            if (cyc == 1) begin
                n_chk++;
                if ({pitch, tone, note_start, playing} !== {3'b100, 7'b0100000, 1'b1, 1'b1}) begin
                    n_fail++;
                    $display("FAIL start_entry0 got %b_%b_%b_%b want 100_0100000_1_1", pitch, tone, note_start, playing);
                end
            end
            if (cyc == 5) begin
                n_chk++;
                if ({pitch, tone, note_idx} !== {3'b100, 7'b1000000, 7'd1}) begin
                    n_fail++;
                    $display("FAIL start_entry1 got %b_%b_%0d want 100_1000000_1", pitch, tone, note_idx);
                end
            end
            if (cyc >= 9 && cyc <= (GAP_ON ? 19 : 20)) begin
                n_chk++;
                if ({pitch, tone, note_idx} !== {3'b010, 7'b0000001, 7'd2}) begin
                    n_fail++;
                    $display("FAIL start_entry2 cyc=%0d got %b_%b_%0d want 010_0000001_2", cyc, pitch, tone, note_idx);
                end
            end
            if (cyc == 21) begin
                n_chk++;
                if ({note_idx, note_start, pitch, tone} !== {7'd3, 1'b1, 3'b010, 7'b0000100}) begin
                    n_fail++;
                    $display("FAIL start_entry3 got idx=%0d s=%b %b_%b want 3 1 010_0000100", note_idx, note_start, pitch, tone);
                end
            end
        end
    endtask

    task automatic test_pause();
        do_reset();
        for (int k = 0; k <= 31; k++) begin
            adv(1'b1, k >= 12 && k <= 21);
            if (cyc >= 13 && cyc <= 22) begin
                n_chk++;
                if ({pitch, tone, note_idx, playing} !== {3'b000, 7'd0, 7'd2, 1'b1}) begin
                    n_fail++;
                    $display("FAIL pause_silent cyc=%0d got %b_%b_%0d_%b want 000_0000000_2_1", cyc, pitch, tone, note_idx, playing);
                end
            end
            if (cyc >= 23 && cyc <= 30) begin
                n_chk++;
                if (note_idx !== 7'd2 || note_start !== 1'b0) begin
                    n_fail++;
                    $display("FAIL pause_hold cyc=%0d got idx=%0d s=%b want 2 0", cyc, note_idx, note_start);
                end
            end
            if (cyc == 31) begin
                n_chk++;
                if ({note_idx, note_start} !== {7'd3, 1'b1}) begin
                    n_fail++;
                    $display("FAIL pause_resume got idx=%0d s=%b want 3 1", note_idx, note_start);
                end
            end
        end
    endtask

    task automatic test_restart();
        do_reset();
        for (int k = 0; k <= 21; k++) begin
            adv(!(k >= 12 && k < 20), 1'b0);
            if (cyc == 12) begin
                n_chk++;
                if (playing !== 1'b1) begin
                    n_fail++;
                    $display("FAIL restart_lag got playing=%b want 1", playing);
                end
            end
            if (cyc == 13) begin
                n_chk++;
                if ({pitch, tone, note_idx, playing} !== 18'd0) begin
                    n_fail++;
                    $display("FAIL restart_stop got %b_%b_%0d_%b want all zero", pitch, tone, note_idx, playing);
                end
            end
            if (cyc == 21) begin
                n_chk++;
                if ({pitch, tone, note_idx, note_start, playing} !== {3'b100, 7'b0100000, 7'd0, 1'b1, 1'b1}) begin
                    n_fail++;
                    $display("FAIL restart_entry0 got %b_%b_%0d_%b_%b want 100_0100000_0_1_1", pitch, tone, note_idx, note_start, playing);
                end
            end
        end
    endtask

    task automatic test_wrap();
        bit seen = 0;
        logic [6:0] prev = 7'd0;
        do_reset();
        for (int k = 0; k < 2000 && !seen; k++) begin
            adv(1'b1, 1'b0);
            n_chk++;
            if ({pitch, tone, note_idx, note_start, playing} !== {e_pitch, e_tone, e_idx, e_start, e_play}) begin
                n_fail++;
                $display("FAIL wrap_model cyc=%0d got %b_%b_%0d_%b_%b want %b_%b_%0d_%b_%b", cyc,
                         pitch, tone, note_idx, note_start, playing, e_pitch, e_tone, e_idx, e_start, e_play);
            end
            seen = prev == 7'(SL - 1) && note_idx == 7'd0 && note_start == 1'b1;
            prev = note_idx;
        end
        n_chk++;
        if (!seen) begin
            n_fail++;
            $display("FAIL wrap_seen got no wrap from %0d to 0 within budget, last idx=%0d", SL - 1, note_idx);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int k = 0; k < 11; k++) adv(1'b1, 1'b0);
        n_chk++;
        if ({pitch, tone, playing} !== {3'b010, 7'b0000001, 1'b1}) begin
            n_fail++;
            $display("FAIL arst_pre got %b_%b_%b want 010_0000001_1", pitch, tone, playing);
        end
        #2;
        rst_n = 0;
        #1;
        n_chk++;
        if ({pitch, tone, note_idx, note_start, playing} !== 19'd0) begin
            n_fail++;
            $display("FAIL arst_now got %b_%b_%0d_%b_%b want all zero", pitch, tone, note_idx, note_start, playing);
        end
        mreset();
    endtask

    task automatic test_random();
        logic a = 1'b1;
        logic p = 1'b0;
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 99) < 3) a = ~a;
            if ($urandom_range(0, 99) < 6) p = ~p;
            adv(a, p);
            n_chk++;
            if ({pitch, tone, note_idx, note_start, playing} !== {e_pitch, e_tone, e_idx, e_start, e_play}) begin
                n_fail++;
                $display("FAIL random_model cyc=%0d got %b_%b_%0d_%b_%b want %b_%b_%0d_%b_%b", cyc,
                         pitch, tone, note_idx, note_start, playing, e_pitch, e_tone, e_idx, e_start, e_play);
            end
        end
    endtask

`ifdef SEQ_NOTE_GAP_EN
    task automatic test_gap();
        do_reset();
        for (int k = 0; k <= 21; k++) begin
            adv(1'b1, 1'b0);
            if (cyc >= 1) begin
                n_chk++;
                if ((tone == 7'd0) !== (cyc == 4 || cyc == 8 || cyc == 20)) begin
                    n_fail++;
                    $display("FAIL gap cyc=%0d got tone=%b want silent=%0d", cyc, tone, cyc == 4 || cyc == 8 || cyc == 20);
                end
            end
        end
    endtask
`endif

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_start();
        test_pause();
        test_restart();
        test_wrap();
        test_async_reset();
        test_random();
`ifdef SEQ_NOTE_GAP_EN
        test_gap();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
